// File: rtl/regfile_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage register file and its interlock controller.
package regfile_hazard_ctrl_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;
  localparam int REG_NUM_W = 5;
  localparam int XZR       = 31;
  localparam int LAT_W_DEF = 3;

  typedef logic [REG_NUM_W-1:0] reg_num_t;

endpackage

// File: rtl/regfile_hazard_ctrl_scoreboard_entry.sv
// One scoreboard slot: remaining write-back latency of a single architectural register.
module scoreboard_entry
  import regfile_hazard_ctrl_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  output logic [LAT_W-1:0] o_cnt,
  output logic             o_busy
);

  logic [LAT_W-1:0] r_cnt;

  // Countdown: a new issue reloads the latency (wins over decrement), otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_lat;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = |r_cnt;

endmodule

// File: rtl/regfile_hazard_ctrl.sv
// Scoreboard interlock for the decode stage: stalls on pending sources/destination,
// tracks in-flight write-backs and counts stall cycles.
module regfile_hazard_ctrl
  import regfile_hazard_ctrl_pkg::*;
#(
  parameter int NREG   = XZR + 1,
  parameter int LAT_W  = LAT_W_DEF,
  parameter int BYPASS = 0,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_num_t         rd1_num,
  input  logic             rd1_used,
  input  reg_num_t         rd2_num,
  input  logic             rd2_used,
  input  logic             issue_valid,
  input  logic             issue_writes,
  input  reg_num_t         issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             flush,
  output logic             stall,
  output logic             issue_fire,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] stall_cycles
);

  // Countdown at or below this value means the result can be forwarded.
  localparam logic [LAT_W-1:0] BYP_TH = LAT_W'(BYPASS);

  logic [LAT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_busy;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_stall;
  logic             w_fire;
  logic [CNT_W-1:0] r_stall_cycles;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The zero register is never tracked, so its slot reads as permanently idle.
  genvar gi;
  generate
    for (gi = 0; gi < NREG - 1; gi++) begin : g_entry
      logic w_load;
      assign w_load = w_fire & issue_writes & (issue_rd == reg_num_t'(gi));
      scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_lat  (issue_lat),
        .o_cnt  (w_cnt[gi]),
        .o_busy (w_busy[gi])
      );
    end
  endgenerate

  assign w_cnt[NREG-1]  = '0;
  assign w_busy[NREG-1] = 1'b0;

  // Hazard detection: RAW honours the forwarding threshold, WAW waits for full retirement.
  always_comb begin
    w_raw1  = rd1_used & (w_cnt[rd1_num] > BYP_TH);
    w_raw2  = rd2_used & (w_cnt[rd2_num] > BYP_TH);
    w_waw   = issue_writes & (w_cnt[issue_rd] != '0);
    w_stall = issue_valid & ~flush & (w_raw1 | w_raw2 | w_waw);
    w_fire  = issue_valid & ~flush & ~w_stall;
  end

  // Performance counter: cycles spent stalled, pinned at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= sat_inc(r_stall_cycles);
    end
  end

  assign stall        = w_stall;
  assign issue_fire   = w_fire;
  assign busy_vec     = w_busy;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/regfile_hazard_ctrl.md
Name: regfile_hazard_ctrl

Overview:
- Scoreboard-based interlock controller for the decode stage and its 32 x 64-bit register file.
- Records each issued instruction's destination register and remaining write-back latency.
- Combinationally stalls decode when a source register (Rn/Rm, or Rt via Reg2Loc) or the destination register is still pending.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- NREG, 32, number of architectural registers; index NREG-1 (X31/XZR) is never tracked.
- LAT_W, 3, width of the per-register latency countdown; maximum latency 2^LAT_W-1.
- BYPASS, 0, countdown value at or below which a pending result is considered forwardable (no stall).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rd1_num  in  5  first read register number (Read_register1 from decode).
- rd1_used  in  1  instruction actually consumes rd1.
- rd2_num  in  5  second read register number (Read_register2, already muxed by Reg2Loc).
- rd2_used  in  1  instruction actually consumes rd2.
- issue_valid  in  1  decode presents an instruction for issue this cycle.
- issue_writes  in  1  instruction writes a register (RegWrite).
- issue_rd  in  5  destination register number (Rd_num).
- issue_lat  in  LAT_W  cycles until the result is written into the register file.
- flush  in  1  squash the instruction in decode this cycle.
- stall  out  1  hold PC and the IF/ID register; insert a bubble.
- issue_fire  out  1  issue accepted this cycle.
- busy_vec  out  NREG  bit i = register i countdown nonzero.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- State: cnt[i] is LAT_W bits for i in 0..NREG-2. cnt[NREG-1] is constant 0.
- Reset (synchronous, dominates all other inputs): all cnt=0, stall_cycles=0. Outputs therefore read busy_vec=0, stall=0, and issue_fire=issue_valid&~flush.
- Hazards, all combinational from the current cnt values:
  - raw1 = rd1_used & cnt[rd1_num]>BYPASS.
  - raw2 = rd2_used & cnt[rd2_num]>BYPASS.
  - waw = issue_writes & cnt[issue_rd]!=0 (strict; no bypass threshold).
- stall = issue_valid & ~flush & (raw1|raw2|waw).
- issue_fire = issue_valid & ~flush & ~stall.
- Per-edge update for every tracked i:
  - If issue_fire & issue_writes & issue_rd==i & i!=NREG-1: cnt[i] <= issue_lat.
  - Else if cnt[i]!=0: cnt[i] <= cnt[i]-1.
  - Else: hold.
- Load has priority over decrement on the same register in the same cycle. This cannot occur in legal flows because waw blocks it, but the RTL must still implement the priority.
- issue_lat=0 with issue_writes=1: the result is written the same cycle, so no entry is created. Register i is loaded with 0, which is effectively a no-op.
- Writes to X31 are never recorded. Reads of X31 never stall.
- flush=1: no issue, no stall, and the scoreboard keeps decrementing. Results already in flight still retire.
- stall_cycles increments when stall=1 and saturates at all-ones. It never wraps.
- Latency: an instruction issued at edge t with latency L keeps its destination busy for the L cycles after t. A dependent reader stalls for exactly L-BYPASS cycles when L>BYPASS.
- Reset mid-operation: all pending entries are dropped. The pipeline is also reset, so no stale write-back exists.
- No registered output depends combinationally on itself. stall has zero-cycle latency from inputs.

Decomposition:
- Shared definitions header (alongside WORD and INSTR_LEN): XZR index 31, REG_NUM_W=5, and the default LAT_W.
- One natural sub-module, scoreboard_entry: one countdown with load/decrement/busy, instantiated NREG-1 times via generate.
- Hazard compare and stall counter live in the top module.

Test Plan:
- Reset, then issue rd=3 with lat=3. Next cycle read rd1=3 with rd1_used=1: stall=1 for 3 cycles, then issue_fire=1 on the 4th; stall_cycles=3.
- BYPASS=1, issue rd=5 with lat=2, then read rd2=5 immediately: stall for 1 cycle only, fire on the 2nd cycle.
- Issue rd=31 with lat=7, then read rd1=31: busy_vec[31]=0, stall=0, immediate fire.
- Issue rd=7 with lat=4, then issue rd=7 again with no sources used: WAW stall for 4 cycles. The second issue then loads cnt[7]=lat.
- Pending rd=9 (cnt=3), assert flush with a dependent reader present: stall=0, issue_fire=0, cnt[9] decrements to 2. Assert reset next: busy_vec=0 the following cycle.
- Force stall_cycles near all-ones (short CNT_W=4 build) and hold a stall for 20 cycles: counter stops at 15.
